// File: rtl/lbm_bank_pingpong.sv
// Ping-pong ownership of two BRAM banks between the DDR cache side and the LBM solver.
// Define PINGPONG_ERR_CHK_EN to build the sticky protocol-error flag; otherwise err is tied 0.
module lbm_bank_pingpong #(
  parameter int unsigned NCH    = 9,
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 12,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                m00_axis_aclk,
  input  logic                m00_axis_areset,
  input  logic [AW-1:0]       cache_addr,
  input  logic                cache_wen,
  input  logic                cache_ren,
  input  logic [NCH*DW-1:0]   cache_wdata,
  output logic [NCH*DW-1:0]   cache_rdata,
  output logic                cache_rvalid,
  input  logic                cache_done,
  output logic                cache_ready,
  input  logic [NCH*AW-1:0]   lbm_addr,
  input  logic [NCH-1:0]      lbm_wen,
  input  logic                lbm_ren,
  input  logic [NCH*DW-1:0]   lbm_wdata,
  output logic [NCH*DW-1:0]   lbm_rdata,
  output logic                lbm_rvalid,
  input  logic                lbm_done,
  output logic                lbm_ready,
  output logic [NCH*AW-1:0]   bankA_addr,
  output logic [NCH-1:0]      bankA_wen,
  output logic [NCH*DW-1:0]   bankA_wdata,
  input  logic [NCH*DW-1:0]   bankA_rdata,
  output logic [NCH*AW-1:0]   bankB_addr,
  output logic [NCH-1:0]      bankB_wen,
  output logic [NCH*DW-1:0]   bankB_wdata,
  input  logic [NCH*DW-1:0]   bankB_rdata,
  output logic                swap_pulse,
  output logic [15:0]         swap_count,
  output logic                err
);

  typedef enum logic [1:0] {FILL, RUN, DRAIN, SWAP} state_e;
  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              cflag_q, cflag_d;
  logic              lflag_q, lflag_d;
  logic [CW-1:0]     dcnt_q, dcnt_d;
  logic [15:0]       swap_cnt_q, swap_cnt_d;
  logic [RD_LAT-1:0] sel_pipe_q, crv_pipe_q, lrv_pipe_q;

  logic [NCH*AW-1:0] c_addr_rep;
  logic [NCH-1:0]    c_wen_g, l_wen_g;

  assign cache_ready = (state_q == FILL) || ((state_q == RUN) && !cflag_q);
  assign lbm_ready   = (state_q == RUN) && !lflag_q;
  assign swap_pulse  = (state_q == SWAP);
  assign swap_count  = swap_cnt_q;

  assign c_addr_rep = {NCH{cache_addr}};
  assign c_wen_g    = {NCH{cache_wen & cache_ready}};
  assign l_wen_g    = lbm_wen & {NCH{lbm_ready}};

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cflag_d    = cflag_q;
    lflag_d    = lflag_q;
    dcnt_d     = dcnt_q;
    swap_cnt_d = swap_cnt_q;
    case (state_q)
      FILL: begin
        if (cache_done) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      RUN: begin
        cflag_d = cflag_q | cache_done;
        lflag_d = lflag_q | lbm_done;
        if (cflag_d && lflag_d) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        // Hold both sides off until reads issued before the lock-out have returned.
        if (dcnt_q == CW'(RD_LAT - 1)) state_d = SWAP;
        else                           dcnt_d  = dcnt_q + 1'b1;
      end
      SWAP: begin
        sel_d      = ~sel_q;
        swap_cnt_d = swap_cnt_q + 16'd1;
        cflag_d    = 1'b0;
        lflag_d    = 1'b0;
        state_d    = RUN;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      state_q    <= FILL;
      sel_q      <= 1'b0;
      cflag_q    <= 1'b0;
      lflag_q    <= 1'b0;
      dcnt_q     <= '0;
      swap_cnt_q <= '0;
      sel_pipe_q <= '0;
      crv_pipe_q <= '0;
      lrv_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cflag_q       <= cflag_d;
      lflag_q       <= lflag_d;
      dcnt_q        <= dcnt_d;
      swap_cnt_q    <= swap_cnt_d;
      sel_pipe_q[0] <= sel_q;
      crv_pipe_q[0] <= cache_ren & cache_ready;
      lrv_pipe_q[0] <= lbm_ren & lbm_ready;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        sel_pipe_q[i] <= sel_pipe_q[i-1];
        crv_pipe_q[i] <= crv_pipe_q[i-1];
        lrv_pipe_q[i] <= lrv_pipe_q[i-1];
      end
    end
  end

  // sel_q=0: cache owns A, solver owns B
  always_comb begin
    bankA_addr  = '0;
    bankA_wen   = '0;
    bankA_wdata = '0;
    bankB_addr  = '0;
    bankB_wen   = '0;
    bankB_wdata = '0;
    if (!m00_axis_areset) begin
      if (!sel_q) begin
        bankA_addr  = c_addr_rep;
        bankA_wen   = c_wen_g;
        bankA_wdata = cache_wdata;
        bankB_addr  = lbm_addr;
        bankB_wen   = l_wen_g;
        bankB_wdata = lbm_wdata;
      end else begin
        bankA_addr  = lbm_addr;
        bankA_wen   = l_wen_g;
        bankA_wdata = lbm_wdata;
        bankB_addr  = c_addr_rep;
        bankB_wen   = c_wen_g;
        bankB_wdata = cache_wdata;
      end
    end
  end

  assign cache_rdata  = sel_pipe_q[RD_LAT-1] ? bankB_rdata : bankA_rdata;
  assign lbm_rdata    = sel_pipe_q[RD_LAT-1] ? bankA_rdata : bankB_rdata;
  assign cache_rvalid = crv_pipe_q[RD_LAT-1];
  assign lbm_rvalid   = lrv_pipe_q[RD_LAT-1];

`ifdef PINGPONG_ERR_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((cache_wen || cache_ren) && !cache_ready) err_d = 1'b1;
    if (((|lbm_wen) || lbm_ren) && !lbm_ready) err_d = 1'b1;
    if (((state_q == DRAIN) || (state_q == SWAP)) && (cache_done || lbm_done)) err_d = 1'b1;
    if ((state_q == RUN) && ((cache_done && cflag_q) || (lbm_done && lflag_q))) err_d = 1'b1;
  end

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) err_q <= 1'b0;
    else                 err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
